// File: rtl/return_addr_stack.sv
// Circular return-address stack for the fetch unit: push on call, pop on return,
// overwrite-oldest when full, with a one-deep pointer/count checkpoint for recovery.
module return_addr_stack #(
  parameter int DATA_WIDTH  = 64,
  parameter int STACK_DEPTH = 16,
  parameter int SP_WIDTH    = 4,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  in_push,
  input  logic                  in_pop,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_flush,
  input  logic                  in_ckpt_save,
  input  logic                  in_ckpt_restore,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_empty,
  output logic                  out_full,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_overflow,
  output logic                  out_underflow
);

  logic [DATA_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [SP_WIDTH-1:0]   sp_q, sp_d, ckpt_sp_q, ckpt_sp_d, top_idx;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, ckpt_cnt_q, ckpt_cnt_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_en;
  logic [SP_WIDTH-1:0]   wr_idx;
  logic                  empty, full;

  assign top_idx = sp_q - SP_WIDTH'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_WIDTH'(STACK_DEPTH));

  assign out_data      = empty ? '0 : mem_q[top_idx];
  assign out_empty     = empty;
  assign out_full      = full;
  assign out_count     = cnt_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sp_d       = sp_q;
    cnt_d      = cnt_q;
    ckpt_sp_d  = ckpt_sp_q;
    ckpt_cnt_d = ckpt_cnt_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = sp_q;

    if (in_flush) begin
      sp_d  = '0;
      cnt_d = '0;
    end else if (in_ckpt_restore) begin
      sp_d  = ckpt_sp_q;
      cnt_d = ckpt_cnt_q;
    end else begin
      if (in_ckpt_save) begin
        ckpt_sp_d  = sp_q;
        ckpt_cnt_d = cnt_q;
      end
      if (in_push && in_pop && !empty) begin
        // Call-and-return in one cycle: replace the top in place.
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (in_push) begin
        wr_en = 1'b1;
        sp_d  = sp_q + SP_WIDTH'(1);
        if (full) ovf_d = 1'b1;
        else      cnt_d = cnt_q + CNT_WIDTH'(1);
      end else if (in_pop) begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          sp_d  = top_idx;
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      sp_q       <= '0;
      cnt_q      <= '0;
      ckpt_sp_q  <= '0;
      ckpt_cnt_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      cnt_q      <= cnt_d;
      ckpt_sp_q  <= ckpt_sp_d;
      ckpt_cnt_q <= ckpt_cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // NOTE: entry storage is reset too, so a stack reached by restore never exposes X.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= in_data;
    end
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack at depth 4: push/pop, overflow wrap,
// underflow, replace-top, checkpoint restore, flush priority and async reset.
module tb_return_addr_stack;

  localparam int DW = 64;
  localparam int DEPTH = 4;
  localparam int SPW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push, pop, flush, save, restore;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          empty, full, ovf, unf;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  return_addr_stack #(
    .DATA_WIDTH(DW), .STACK_DEPTH(DEPTH), .SP_WIDTH(SPW), .CNT_WIDTH(CW)
  ) dut (
    .in_Clk(clk), .in_Rst_N(rst_n), .in_push(push), .in_pop(pop), .in_data(din),
    .in_flush(flush), .in_ckpt_save(save), .in_ckpt_restore(restore),
    .out_data(dout), .out_empty(empty), .out_full(full), .out_count(count),
    .out_overflow(ovf), .out_underflow(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of controls, clock it, then return #1 after the edge.
  task automatic cyc(input logic p, input logic q, input logic [DW-1:0] d,
                     input logic f, input logic s, input logic r);
    push = p; pop = q; din = d; flush = f; save = s; restore = r;
    @(posedge clk);
    #1;
    push = 0; pop = 0; din = '0; flush = 0; save = 0; restore = 0;
  endtask

  task automatic do_push(input logic [DW-1:0] d); cyc(1, 0, d, 0, 0, 0); endtask
  task automatic do_pop();                         cyc(0, 1, '0, 0, 0, 0); endtask
  task automatic do_idle();                        cyc(0, 0, '0, 0, 0, 0); endtask
  task automatic do_flush();                       cyc(0, 0, '0, 1, 0, 0); endtask

  initial begin
    push = 0; pop = 0; din = '0; flush = 0; save = 0; restore = 0;
    rst_n = 1'b0;
    #12;
    check("rst_data", dout, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic push/pop
    do_push(64'h1000);
    do_push(64'h2000);
    check("t1_data2", dout, 64'h2000);
    check("t1_cnt2", count, 2);
    do_pop();
    check("t1_pop_data", dout, 64'h1000);
    check("t1_pop_cnt", count, 1);
    do_flush();
    check("t1_flush_empty", empty, 1);

    // 2: overflow overwrites the oldest entry
    for (int i = 1; i <= 4; i++) do_push(64'(i));
    check("t2_full4", full, 1);
    check("t2_ovf_none", ovf, 0);
    do_push(64'd5);
    check("t2_ovf", ovf, 1);
    check("t2_cnt", count, 4);
    check("t2_full", full, 1);
    check("t2_top5", dout, 64'd5);
    do_idle();
    check("t2_ovf_1cyc", ovf, 0);
    do_pop(); check("t2_pop4", dout, 64'd4);
    do_pop(); check("t2_pop3", dout, 64'd3);
    do_pop(); check("t2_pop2", dout, 64'd2);
    check("t2_cnt1", count, 1);
    do_pop();
    check("t2_empty", empty, 1);
    check("t2_empty_data", dout, 0);

    // 3: underflow, then push+pop on empty acts as push
    do_pop();
    check("t3_unf", unf, 1);
    check("t3_cnt", count, 0);
    check("t3_data", dout, 0);
    do_idle();
    check("t3_unf_1cyc", unf, 0);
    cyc(1, 1, 64'hA, 0, 0, 0);
    check("t3_pp_cnt", count, 1);
    check("t3_pp_data", dout, 64'hA);
    check("t3_pp_unf", unf, 0);
    do_flush();

    // 4: replace top
    do_push(64'h10);
    do_push(64'h20);
    cyc(1, 1, 64'h30, 0, 0, 0);
    check("t4_data", dout, 64'h30);
    check("t4_cnt", count, 2);
    do_pop();
    check("t4_pop_data", dout, 64'h10);
    do_flush();

    // 5: checkpoint save/restore and flush priority
    do_push(64'h10);
    cyc(0, 0, '0, 0, 1, 0);
    do_push(64'h20);
    do_push(64'h30);
    check("t5_cnt3", count, 3);
    cyc(0, 0, '0, 0, 0, 1);
    check("t5_rst_cnt", count, 1);
    check("t5_rst_data", dout, 64'h10);
    cyc(1, 0, 64'h99, 1, 0, 0);
    check("t5_flush_push", count, 0);
    cyc(1, 0, 64'h77, 0, 0, 1);
    check("t5_restore_ign_cnt", count, 1);
    check("t5_restore_ign_data", dout, 64'h10);
    do_push(64'h1);
    do_push(64'h1);
    do_push(64'h1);
    cyc(0, 0, '0, 1, 1, 0);
    cyc(0, 0, '0, 0, 0, 1);
    check("t5_save_under_flush", count, 1);

    // 6: asynchronous reset between edges
    do_flush();
    do_push(64'h111);
    do_push(64'h222);
    do_push(64'h333);
    check("t6_pre_cnt", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_cnt", count, 0);
    check("t6_empty", empty, 1);
    check("t6_full", full, 0);
    check("t6_data", dout, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(0, 0, '0, 0, 0, 1);
    check("t6_ckpt_cleared", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
